dmem_copy_engine: RTL

Block-copy initiator for the 8-bit data memory. On a start pulse it walks a source range, reading one byte per access, and writes each byte to a destination range in the same memory. It drives the memory's read/write strobes, address and write data, and consumes its combinational read data. It sits beside the datapath's load/store path on the data-memory port, and the top level muxes this port to the engine while `busy` is high.

---
 rtl/dmem_copy_pkg.sv | 6 +
 rtl/dmem_copy_engine.sv | 78 +++++++
 2 files changed

// File: rtl/dmem_copy_pkg.sv
// dmem_copy_pkg: shared state encoding and width defaults for the data-memory copy engine.
package dmem_copy_pkg;
    localparam int ADDR_WIDTH_DEF = 8;
    localparam int DATA_WIDTH_DEF = 8;
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
endpackage

// File: rtl/dmem_copy_engine.sv
// dmem_copy_engine: memmove-safe block copy within the data memory, one READ and one WRITE cycle per byte.
module dmem_copy_engine
    import dmem_copy_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] srcAddr,
    input  logic [ADDR_WIDTH-1:0] dstAddr,
    input  logic [7:0]            length,
    output logic                  busy,
    output logic                  done,
    output logic                  sigMemRead,
    output logic                  sigMemWrite,
    output logic [ADDR_WIDTH-1:0] dataAddress,
    output logic [DATA_WIDTH-1:0] writeData,
    input  logic [DATA_WIDTH-1:0] readData
);
    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_src;
    logic [ADDR_WIDTH-1:0] r_dst;
    logic [7:0]            r_cnt;
    logic [DATA_WIDTH-1:0] r_buf;
    logic                  r_desc;
    logic [ADDR_WIDTH-1:0] w_diff;
    logic                  w_desc;
    logic [ADDR_WIDTH-1:0] w_off;
    logic [ADDR_WIDTH-1:0] w_step;

    // Destination starting inside the source range would clobber unread bytes, so walk backwards.
    assign w_diff = dstAddr - srcAddr;
    assign w_desc = (w_diff != '0) && (32'(w_diff) < 32'(length));
    assign w_off  = w_desc ? ADDR_WIDTH'(length) - ADDR_WIDTH'(1) : '0;
    assign w_step = r_desc ? '1 : ADDR_WIDTH'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_cnt   <= '0;
            r_buf   <= '0;
            r_desc  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_src   <= srcAddr + w_off;
                    r_dst   <= dstAddr + w_off;
                    r_cnt   <= length;
                    r_desc  <= w_desc;
                    r_state <= (length != 8'd0) ? READ : DONE;
                end
                READ: begin
                    r_buf   <= readData;
                    r_state <= WRITE;
                end
                WRITE: begin
                    r_src   <= r_src + w_step;
                    r_dst   <= r_dst + w_step;
                    r_cnt   <= r_cnt - 8'd1;
                    r_state <= (r_cnt != 8'd1) ? READ : DONE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Port outputs decode registered state only, so reset clears them without waiting for a clock.
    assign busy        = (r_state == READ) || (r_state == WRITE);
    assign done        = (r_state == DONE);
    assign sigMemRead  = (r_state == READ);
    assign sigMemWrite = (r_state == WRITE);
    assign dataAddress = (r_state == READ) ? r_src : (r_state == WRITE) ? r_dst : '0;
    assign writeData   = (r_state == WRITE) ? r_buf : '0;
endmodule
